// File: rtl/fast9_pkg.sv
// Shared definitions for the FAST9 neighbour-fetch controller.
//   fetchState_t : controller FSM states
//   NUM_ADJ      : neighbours per centre
//   DRAIN_CYCLES : cycles the read/steer pipeline needs to empty after the last read
//   ADJ_DX/ADJ_DY: signed (dx,dy) offset of each matrix slot, clockwise from top-left
package fast9_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    DRAIN   = 3'd2,
    PRESENT = 3'd3,
    FIN     = 3'd4
  } fetchState_t;

  localparam int NUM_ADJ      = 8;
  localparam int DRAIN_CYCLES = 2;

  // Slot order: 0(-1,-1) 1(0,-1) 2(+1,-1) 3(+1,0) 4(+1,+1) 5(0,+1) 6(-1,+1) 7(-1,0)
  localparam logic signed [1:0] ADJ_DX [NUM_ADJ] =
    '{2'sb11, 2'sb00, 2'sb01, 2'sb01, 2'sb01, 2'sb00, 2'sb11, 2'sb11};
  localparam logic signed [1:0] ADJ_DY [NUM_ADJ] =
    '{2'sb11, 2'sb11, 2'sb11, 2'sb00, 2'sb01, 2'sb01, 2'sb01, 2'sb00};

endpackage

// File: rtl/fast9_adj_addr_gen.sv
// Combinational frame-buffer address of one neighbour of a centre pixel.
//   centreX, centreY : centre coordinates (always interior)
//   slot             : neighbour slot 0..7
//   fbAddr           : (centreY+dy)*IMG_W + (centreX+dx), unsigned, ADDR_W bits
module fast9_adj_addr_gen
  import fast9_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic [$clog2(IMG_W)-1:0] centreX,
  input  logic [$clog2(IMG_H)-1:0] centreY,
  input  logic [2:0]               slot,
  output logic [ADDR_W-1:0]        fbAddr
);

  logic [ADDR_W-1:0] rowIdx;
  logic [ADDR_W-1:0] colIdx;

  // The signed offsets are sign-extended to ADDR_W, so adding -1 wraps
  // modulo 2^ADDR_W; interior centres keep the true result in range.
  always_comb begin
    rowIdx = ADDR_W'(centreY) + ADDR_W'(ADJ_DY[slot]);
    colIdx = ADDR_W'(centreX) + ADDR_W'(ADJ_DX[slot]);
    fbAddr = ADDR_W'(rowIdx * ADDR_W'(IMG_W)) + colIdx;
  end

endmodule

// File: rtl/fast9_adj_fetch_ctrl.sv
// FAST9 8-neighbour matrix fetch controller.
// Scans every interior pixel as a centre in raster order, issues 8 frame-buffer
// reads per centre, steers the returned bytes into matrix slots 0..7 and then
// presents the neighbourhood to the datapath until it is accepted.
// Ports:
//   clock, nReset         : clock (rising edge), asynchronous active-low reset
//   start                 : begin a full-frame scan (accepted only in IDLE)
//   busy, done            : scan in progress / one-cycle end-of-frame pulse
//   fbRen, fbAddr         : frame-buffer read request
//   fbRdData              : frame-buffer read data, one cycle after fbRen
//   regAddr, regData      : registered matrix write port (written every cycle)
//   matReaden, dpValid    : neighbourhood valid; dpReady completes the handoff
//   centerX, centerY      : current centre coordinates
//   stallCnt              : PRESENT cycles without dpReady, saturating
//                           (only when FAST9_STALL_CNT_EN is defined)
module fast9_adj_fetch_ctrl
  import fast9_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic                     clock,
  input  logic                     nReset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     fbRen,
  output logic [ADDR_W-1:0]        fbAddr,
  input  logic [7:0]               fbRdData,
  output logic [2:0]               regAddr,
  output logic [7:0]               regData,
  output logic                     matReaden,
  output logic                     dpValid,
  input  logic                     dpReady,
  output logic [$clog2(IMG_W)-1:0] centerX,
  output logic [$clog2(IMG_H)-1:0] centerY
`ifdef FAST9_STALL_CNT_EN
  ,
  output logic [15:0]              stallCnt
`endif
);

  localparam int CX_W = $clog2(IMG_W);
  localparam int CY_W = $clog2(IMG_H);
  localparam logic [CX_W-1:0] LAST_X = CX_W'(IMG_W - 2);
  localparam logic [CY_W-1:0] LAST_Y = CY_W'(IMG_H - 2);

  fetchState_t       state;
  fetchState_t       nextState;
  logic [2:0]        phaseCnt;
  logic              startOk;
  logic              handshake;
  logic              lastCentre;
  logic              issueLast;
  logic              drainLast;
  logic [ADDR_W-1:0] slotAddr;
  logic [2:0]        slot_p1;
  logic              vld_p1;

  assign startOk    = (state == IDLE) && start;
  assign handshake  = (state == PRESENT) && dpReady;
  assign lastCentre = (centerX == LAST_X) && (centerY == LAST_Y);
  assign issueLast  = (phaseCnt == 3'(NUM_ADJ - 1));
  assign drainLast  = (phaseCnt == 3'(DRAIN_CYCLES - 1));

  fast9_adj_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) uAddrGen (
    .centreX (centerX),
    .centreY (centerY),
    .slot    (phaseCnt),
    .fbAddr  (slotAddr)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start)     nextState = ISSUE;
      ISSUE:   if (issueLast) nextState = DRAIN;
      DRAIN:   if (drainLast) nextState = PRESENT;
      PRESENT: if (dpReady)   nextState = lastCentre ? FIN : ISSUE;
      FIN:                    nextState = IDLE;
      default:                nextState = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    fbRen     = (state == ISSUE);
    matReaden = (state == PRESENT);
    dpValid   = (state == PRESENT);
    fbAddr    = (state == ISSUE) ? slotAddr : '0;
  end

  // Shared phase counter: read slot index in ISSUE, elapsed cycles in DRAIN.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      phaseCnt <= '0;
    end else if (state == ISSUE) begin
      phaseCnt <= issueLast ? 3'd0 : phaseCnt + 3'd1;
    end else if (state == DRAIN) begin
      phaseCnt <= drainLast ? 3'd0 : phaseCnt + 3'd1;
    end else begin
      phaseCnt <= '0;
    end
  end

  // Raster advance over the interior; wraps x to 1 at the right edge.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      centerX <= '0;
      centerY <= '0;
    end else if (startOk) begin
      centerX <= CX_W'(1);
      centerY <= CY_W'(1);
    end else if (handshake && !lastCentre) begin
      if (centerX == LAST_X) begin
        centerX <= CX_W'(1);
        centerY <= centerY + CY_W'(1);
      end else begin
        centerX <= centerX + CX_W'(1);
      end
    end
  end

  // Stage p1: read in flight, its data arrives on fbRdData this cycle.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) vld_p1 <= 1'b0;
    else         vld_p1 <= fbRen;
  end

  always_ff @(posedge clock) begin
    slot_p1 <= phaseCnt;
  end

  // Stage p2: registered matrix write port. When idle it parks on slot 7 with
  // the last slot-7 byte, so the unconditional matrix write is harmless.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      regAddr <= 3'd7;
      regData <= 8'd0;
    end else if (vld_p1) begin
      regAddr <= slot_p1;
      regData <= fbRdData;
    end else begin
      regAddr <= 3'd7;
    end
  end

`ifdef FAST9_STALL_CNT_EN
  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      stallCnt <= 16'd0;
    end else if (startOk) begin
      stallCnt <= 16'd0;
    end else if ((state == PRESENT) && !dpReady) begin
      stallCnt <= satInc16(stallCnt);
    end
  end
`endif

endmodule

// File: tb/tb_fast9_adj_fetch_ctrl.sv
// Self-checking bench for fast9_adj_fetch_ctrl on a 4x4 frame.
// Environment: frame buffer returning addr[7:0] one cycle after the read, and
// an 8-byte matrix written from regAddr/regData on every clock.
module tb_fast9_adj_fetch_ctrl;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NC = (W - 2) * (H - 2);

  logic       clock;
  logic       nReset;
  logic       start;
  logic       busy;
  logic       done;
  logic       fbRen;
  logic [3:0] fbAddr;
  logic [7:0] fbRdData;
  logic [2:0] regAddr;
  logic [7:0] regData;
  logic       matReaden;
  logic       dpValid;
  logic       dpReady;
  logic [1:0] centerX;
  logic [1:0] centerY;
`ifdef FAST9_STALL_CNT_EN
  logic [15:0] stallCnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] mat [8];

  fast9_adj_fetch_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clock     (clock),
    .nReset    (nReset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fbRen     (fbRen),
    .fbAddr    (fbAddr),
    .fbRdData  (fbRdData),
    .regAddr   (regAddr),
    .regData   (regData),
    .matReaden (matReaden),
    .dpValid   (dpValid),
    .dpReady   (dpReady),
    .centerX   (centerX),
    .centerY   (centerY)
`ifdef FAST9_STALL_CNT_EN
    ,
    .stallCnt  (stallCnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) fbRdData <= 8'(fbAddr);
  always @(posedge clock) mat[regAddr] <= regData;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference geometry: neighbour k of the idx-th interior centre in raster order.
  function automatic int nbrAddr(input int idx, input int k);
    int dx [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int dy [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
    int cx, cy;
    cx = 1 + idx % (W - 2);
    cy = 1 + idx / (W - 2);
    return (cy + dy[k]) * W + (cx + dx[k]);
  endfunction

  function automatic logic [63:0] expMatrix(input int idx);
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v = {v[55:0], 8'(nbrAddr(idx, k))};
    return v;
  endfunction

  task automatic checkResetVals();
    checkVal("rstBusy", busy, 0);
    checkVal("rstDone", done, 0);
    checkVal("rstFbRen", fbRen, 0);
    checkVal("rstFbAddr", fbAddr, 0);
    checkVal("rstRegAddr", regAddr, 7);
    checkVal("rstRegData", regData, 0);
    checkVal("rstMatReaden", matReaden, 0);
    checkVal("rstDpValid", dpValid, 0);
    checkVal("rstCenterX", centerX, 0);
    checkVal("rstCenterY", centerY, 0);
`ifdef FAST9_STALL_CNT_EN
    checkVal("rstStallCnt", stallCnt, 0);
`endif
  endtask

  // mode 0: dpReady high; 1: 5 stall cycles on first centre; 2: random.
  // noise: random start pulses while busy. abortSlot >= 0: reset at that read.
  task automatic runScan(input int mode, input bit noise, input int abortSlot);
    int idx = 0, k = 0, cyc = 0, firstRen = 0, presentCnt = 0;
    int lastHs = -100, stallExp = 0, extraDone = 0;
    bit seenDone = 0;
    logic [63:0] matVal;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checkVal("busyAfterStart", busy, 1);
`ifdef FAST9_STALL_CNT_EN
    checkVal("stallCntCleared", stallCnt, 0);
`endif
    while (!seenDone && cyc < 2000) begin
      if (matReaden) begin
        case (mode)
          0:       dpReady = 1'b1;
          1:       dpReady = (idx == 0 && presentCnt < 5) ? 1'b0 : 1'b1;
          default: dpReady = ($urandom_range(0, 2) != 0);
        endcase
      end else begin
        dpReady = 1'($urandom_range(0, 1));
      end
      start = noise ? ($urandom_range(0, 4) == 0) : 1'b0;
      if (fbRen) begin
        checkVal("fbAddr", fbAddr, 64'(nbrAddr(idx, k)));
        if (k == 0) firstRen = cyc;
        if (abortSlot == k) begin
          nReset = 1'b0;
          start = 1'b0;
          #1;
          checkResetVals();
          @(negedge clock);
          nReset = 1'b1;
          dpReady = 1'b1;
          @(posedge clock); #1;
          checkVal("busyAfterAbort", busy, 0);
          return;
        end
        k++;
      end
      if (matReaden) begin
        matVal = {mat[0], mat[1], mat[2], mat[3], mat[4], mat[5], mat[6], mat[7]};
        if (presentCnt == 0) begin
          checkVal("fetchLatency", 64'(cyc - firstRen), 10);
          checkVal("slotsIssued", 64'(k), 8);
          if (idx == 0) checkVal("mat11", matVal, 64'h0001_0206_0A09_0804);
        end
        checkVal("matrix", matVal, expMatrix(idx));
        checkVal("centerX", centerX, 64'(1 + idx % (W - 2)));
        checkVal("centerY", centerY, 64'(1 + idx / (W - 2)));
        checkVal("dpValid", dpValid, 1);
        checkVal("fbRenInPresent", fbRen, 0);
        checkVal("regAddrHeld", regAddr, 7);
        checkVal("regDataHeld", regData, 64'(8'(nbrAddr(idx, 7))));
        presentCnt++;
        if (!dpReady) stallExp++;
        if (dpReady) begin
          lastHs = cyc;
          idx++;
          k = 0;
          presentCnt = 0;
        end
      end
      if (done) begin
        checkVal("doneAfterLastHs", 64'(cyc - lastHs), 1);
        checkVal("handoffs", 64'(idx), 64'(NC));
        seenDone = 1;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    dpReady = 1'b1;
    if (!seenDone) checkVal("doneTimeout", 0, 1);
`ifdef FAST9_STALL_CNT_EN
    checkVal("stallCnt", stallCnt, 64'(stallExp));
`endif
    for (int i = 0; i < 3; i++) begin
      checkVal("busyIdle", busy, 0);
      extraDone += int'(done);
      @(posedge clock); #1;
    end
    checkVal("extraDone", 64'(extraDone), 0);
  endtask

  initial begin
    nReset  = 1'b0;
    start   = 1'b0;
    dpReady = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkResetVals();
    @(negedge clock);
    nReset = 1'b1;
    @(posedge clock); #1;
    checkVal("idleBusy", busy, 0);
    runScan(0, 0, -1);
    runScan(1, 0, -1);
    runScan(2, 1, -1);
    runScan(0, 0, 3);
    runScan(0, 0, -1);
    for (int r = 0; r < 4; r++) runScan(2, 1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
